// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM state encoding and chunk-count helpers for the
// multi-cycle subtract/compare unit.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of CHUNK-bit slices needed to cover WIDTH bits.
  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Counter width for a given chunk count; one spare bit keeps the
  // terminal value representable even when the count is a power of two.
  function automatic int cnt_width(input int n_chunks);
    return $clog2(n_chunks) + 1;
  endfunction

endpackage

// File: rtl/chunk_subtract.sv
// One CHUNK-bit slice of a - b, computed as a + ~b + cin.
// A carry out of 1 means "no borrow" out of this slice.
module chunk_subtract #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_chunk,
  input  logic [CHUNK-1:0] b_chunk,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  // Widen by one bit so the carry out lands in the top bit.
  always_comb begin
    {cout, sum} = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK{1'b0}}, cin};
  end

endmodule

// File: rtl/multicycle_subtract_compare.sv
// Multi-cycle A-B subtractor/comparator. Operands are consumed CHUNK bits per
// cycle, least-significant slice first, with the slice carry held in a
// register between cycles. Results and flags are registered on entry to DONE
// and held until the consumer takes them.
module multicycle_subtract_compare
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             less_than,
  output logic             not_equal,
  output logic             overflow,
  output logic             borrow
);

  localparam int NUM_CHUNKS = num_chunks(WIDTH, CHUNK);
  localparam int CNT_W      = cnt_width(NUM_CHUNKS);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_chunk_check
    $error("multicycle_subtract_compare: CHUNK (%0d) must divide WIDTH (%0d)", CHUNK, WIDTH);
  end

  state_t             state_q, state_d;
  logic               accept;
  logic               run_last;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               nz_q;

  logic [WIDTH-1:0]   a_q, b_q;
  logic               sg_q, a_msb_q, b_msb_q;
  logic [WIDTH-1:0]   diff_run_q;

  logic               cin;
  logic [CHUNK-1:0]   chunk_sum;
  logic               chunk_cout;
  logic [WIDTH-1:0]   sum_ext;
  logic [WIDTH-1:0]   diff_next;
  logic               diff_msb;
  logic               ovf_next;
  logic               lt_next;
  logic               nz_next;

  logic [WIDTH-1:0]   diff_q;
  logic               lt_q, ne_q, ovf_q, br_q;

  // Single slice adder, reused every RUN cycle on the low slice of the
  // shifting operand registers.
  chunk_subtract #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a_chunk (a_q[CHUNK-1:0]),
    .b_chunk (b_q[CHUNK-1:0]),
    .cin     (cin),
    .sum     (chunk_sum),
    .cout    (chunk_cout)
  );

  // Slice datapath: carry-in select, diff assembly and final flag terms.
  always_comb begin
    cin       = (cnt_q == '0) ? 1'b1 : carry_q;
    sum_ext   = WIDTH'(chunk_sum);
    diff_next = (diff_run_q >> CHUNK) | (sum_ext << (WIDTH - CHUNK));
    diff_msb  = chunk_sum[CHUNK-1];
    ovf_next  = (a_msb_q ^ b_msb_q) & (diff_msb ^ a_msb_q);
    lt_next   = sg_q ? (diff_msb ^ ovf_next) : ~chunk_cout;
    nz_next   = ((cnt_q == '0) ? 1'b0 : nz_q) | (|chunk_sum);
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (run_last) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and control strobes.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    out_valid = (state_q == DONE);
    accept    = in_valid && in_ready;
    run_last  = (state_q == RUN) && (cnt_q == CNT_W'(NUM_CHUNKS - 1));
  end

  // Chunk counter, inter-slice carry and nonzero accumulator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      nz_q    <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      cnt_q   <= cnt_q + 1'b1;
      carry_q <= chunk_cout;
      nz_q    <= nz_next;
    end
  end

  // Operand capture on accept, then shift one slice down per RUN cycle.
  always_ff @(posedge clock) begin
    if (accept) begin
      a_q     <= a;
      b_q     <= b;
      sg_q    <= is_signed;
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_q        <= a_q >> CHUNK;
      b_q        <= b_q >> CHUNK;
      diff_run_q <= diff_next;
    end
  end

  // Result registers: loaded only as the last slice completes, so a
  // partial result is never visible and an aborted run leaves them cleared.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      diff_q <= '0;
      lt_q   <= 1'b0;
      ne_q   <= 1'b0;
      ovf_q  <= 1'b0;
      br_q   <= 1'b0;
    end else if (run_last) begin
      diff_q <= diff_next;
      lt_q   <= lt_next;
      ne_q   <= nz_next;
      ovf_q  <= ovf_next;
      br_q   <= ~chunk_cout;
    end
  end

  assign diff      = diff_q;
  assign less_than = lt_q;
  assign not_equal = ne_q;
  assign overflow  = ovf_q;
  assign borrow    = br_q;

endmodule

// File: tb/tb_multicycle_subtract_compare.sv
// Directed bench for multicycle_subtract_compare (WIDTH=32, CHUNK=8).
module tb_multicycle_subtract_compare;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int LAT   = WIDTH / CHUNK;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             is_signed = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             less_than;
  logic             not_equal;
  logic             overflow;
  logic             borrow;

  int total = 0;
  int bad   = 0;

  multicycle_subtract_compare #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .less_than (less_than),
    .not_equal (not_equal),
    .overflow  (overflow),
    .borrow    (borrow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic             sg;
    logic [WIDTH-1:0] d;
    logic             lt;
    logic             ne;
    logic             ov;
    logic             br;
  } vec_t;

  // Present one operation at a negedge; return just after its accept edge.
  task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sg);
    @(negedge clock);
    a = av; b = bv; is_signed = sg; in_valid = 1'b1;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  // Count rising edges until out_valid appears; -1 if it never does.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_result;
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    total++;
    if ({diff, less_than, not_equal, overflow, borrow} !== {32'h0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_res: diff=%h flags=%b%b%b%b required 0 0000", diff, less_than, not_equal, overflow, borrow);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_vectors;
    vec_t v[8];
    int   lat;
    v[0] = '{32'd5,        32'd3,        1'b1, 32'd2,        1'b0, 1'b1, 1'b0, 1'b0};
    v[1] = '{32'd3,        32'd5,        1'b0, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 1'b1};
    v[2] = '{32'd3,        32'd5,        1'b1, 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 1'b1};
    v[3] = '{32'h80000000, 32'd1,        1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0};
    v[4] = '{32'h80000000, 32'd1,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    v[5] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    v[6] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0};
    v[7] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      start_op(v[i].av, v[i].bv, v[i].sg);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_busy: out_valid=%b required 0 right after accept", i, out_valid);
      end
      wait_result(lat);
      total++;
      if (lat !== LAT) begin
        bad++;
        $display("FAIL vec%0d_latency: got %0d cycles required %0d", i, lat, LAT);
      end
      total++;
      if (diff !== v[i].d) begin
        bad++;
        $display("FAIL vec%0d_diff: got %h required %h", i, diff, v[i].d);
      end
      total++;
      if ({less_than, not_equal, overflow, borrow} !== {v[i].lt, v[i].ne, v[i].ov, v[i].br}) begin
        bad++;
        $display("FAIL vec%0d_flags: lt/ne/ovf/br got %b%b%b%b required %b%b%b%b", i,
                 less_than, not_equal, overflow, borrow, v[i].lt, v[i].ne, v[i].ov, v[i].br);
      end
      release_result();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL vec%0d_release: out_valid=%b in_ready=%b required 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(32'd10, 32'd20, 1'b1);
    wait_result(lat);
    total++;
    if (lat !== LAT || diff !== 32'hFFFFFFF6) begin
      bad++;
      $display("FAIL b2b_first: lat=%0d diff=%h required %0d fffffff6", lat, diff, LAT);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 32'hFFFFFFF6 ||
          {less_than, not_equal, overflow, borrow} !== 4'b1101) begin
        bad++;
        $display("FAIL b2b_hold%0d: ov=%b ir=%b diff=%h flags=%b%b%b%b required 1 0 fffffff6 1101",
                 c, out_valid, in_ready, diff, less_than, not_equal, overflow, borrow);
      end
    end
    // Consume the result and offer the next op on the same edge.
    @(negedge clock);
    out_ready = 1'b1; in_valid = 1'b1; a = 32'd100; b = 32'd1; is_signed = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clock);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || diff !== 32'hFFFFFFF6) begin
      bad++;
      $display("FAIL b2b_run: out_valid=%b diff=%h required 0 fffffff6", out_valid, diff);
    end
    wait_result(lat);
    total++;
    if (lat !== LAT) begin
      bad++;
      $display("FAIL b2b_latency: got %0d required %0d", lat, LAT);
    end
    total++;
    if (diff !== 32'd99 || {less_than, not_equal, overflow, borrow} !== 4'b0100) begin
      bad++;
      $display("FAIL b2b_second: diff=%h flags=%b%b%b%b required 00000063 0100",
               diff, less_than, not_equal, overflow, borrow);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run;
    int lat;
    // Leave a nonzero result in the output registers first.
    start_op(32'd9, 32'd4, 1'b0);
    wait_result(lat);
    release_result();
    start_op(32'hFFFF0000, 32'h0000FFFF, 1'b0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_hs: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    total++;
    if ({diff, less_than, not_equal, overflow, borrow} !== {32'h0, 4'b0000}) begin
      bad++;
      $display("FAIL abort_res: diff=%h flags=%b%b%b%b required 0 0000", diff, less_than, not_equal, overflow, borrow);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    start_op(32'h12345678, 32'h11111111, 1'b1);
    wait_result(lat);
    total++;
    if (lat !== LAT || diff !== 32'h01234567) begin
      bad++;
      $display("FAIL abort_fresh: lat=%0d diff=%h required %0d 01234567", lat, diff, LAT);
    end
    total++;
    if ({less_than, not_equal, overflow, borrow} !== 4'b0100) begin
      bad++;
      $display("FAIL abort_flags: got %b%b%b%b required 0100", less_than, not_equal, overflow, borrow);
    end
    release_result();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
